multicycle_control: RTL and testbench

Moore-style main control FSM for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback steps. It drives the program counter's write enable (PCWrite) and next-PC source select, plus all datapath mux, memory, instruction-register and register-file enables. It sits upstream of the program counter and consumes the instruction opcode and the ALU Zero flag.

---
 rtl/multicycle_control_if.sv | 32 +++
 rtl/multicycle_control.sv | 160 ++++++++++++++++
 tb/tb_multicycle_control.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multicycle MIPS main control FSM.
interface multicycle_control_if;
  logic [5:0] Op;
  logic       Zero;
  logic       PCWrite;
  logic [1:0] PCSource;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [3:0] State;

  // Control side: consumes opcode and zero flag, drives datapath controls.
  modport master (
    input  Op, Zero,
    output PCWrite, PCSource, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, State
  );

  // Datapath side: supplies opcode and zero flag, obeys the controls.
  modport slave (
    output Op, Zero,
    input  PCWrite, PCSource, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, State
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore main control FSM for the multicycle MIPS datapath.
module multicycle_control (
  input logic                  clock,
  input logic                  reset,
  multicycle_control_if.master bus
);

  localparam int unsigned OP_W = 6;
  localparam int unsigned ST_W = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;

  typedef enum logic [ST_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPE_EX = 4'd6,
    RTYPE_WB = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    ADDI_EX  = 4'd10,
    ADDI_WB  = 4'd11
  } state_t;

  state_t     state_q;
  state_t     state_d;

  logic       pc_write;
  logic [1:0] pc_source;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore output decode; PCWrite in BRANCH also looks at Op/Zero.
  always_comb begin
    state_d    = FETCH;
    pc_write   = 1'b0;
    pc_source  = 2'd0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;

    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = 2'd1;
        pc_write  = 1'b1;
        state_d   = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'd3;
        case (bus.Op)
          OP_LW, OP_SW:   state_d = MEMADR;
          OP_RTYPE:       state_d = RTYPE_EX;
          OP_ADDI:        state_d = ADDI_EX;
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_J:           state_d = JUMP;
          default:        state_d = FETCH;
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = (bus.Op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      RTYPE_EX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd2;
        state_d   = RTYPE_WB;
      end
      RTYPE_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd1;
        pc_source = 2'd1;
        pc_write  = ((bus.Op == OP_BEQ) &&  bus.Zero) ||
                    ((bus.Op == OP_BNE) && !bus.Zero);
      end
      JUMP: begin
        pc_source = 2'd2;
        pc_write  = 1'b1;
      end
      ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = ADDI_WB;
      end
      ADDI_WB: begin
        reg_write = 1'b1;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign bus.PCWrite  = pc_write;
  assign bus.PCSource = pc_source;
  assign bus.IorD     = i_or_d;
  assign bus.MemRead  = mem_read;
  assign bus.MemWrite = mem_write;
  assign bus.IRWrite  = ir_write;
  assign bus.MemtoReg = mem_to_reg;
  assign bus.RegDst   = reg_dst;
  assign bus.RegWrite = reg_write;
  assign bus.ALUSrcA  = alu_src_a;
  assign bus.ALUSrcB  = alu_src_b;
  assign bus.ALUOp    = alu_op;
  assign bus.State    = ST_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed vector table,
// per-instruction cycle counts, and a randomized run against an
// instruction-level reference model.
module tb_multicycle_control;

  logic clock;
  logic reset;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks;
  int errors;

  // Full control word, in a fixed bit order.
  typedef struct packed {
    logic       pcw;
    logic [1:0] pcs;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       m2r;
    logic       rd;
    logic       rw;
    logic       sa;
    logic [1:0] sb;
    logic [1:0] aop;
  } outs_t;

  // One directed cycle: inputs applied, state and key outputs expected.
  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       zero;
    int         st;
    logic       pcw;
    logic [1:0] pcs;
    logic       rw;
    logic       mw;
    logic       mr;
    logic       rd;
    logic       iord;
  } vec_t;

  vec_t vecs[$];

  function automatic outs_t dut_outs();
    outs_t o;
    o.pcw  = bus.PCWrite;
    o.pcs  = bus.PCSource;
    o.iord = bus.IorD;
    o.mr   = bus.MemRead;
    o.mw   = bus.MemWrite;
    o.irw  = bus.IRWrite;
    o.m2r  = bus.MemtoReg;
    o.rd   = bus.RegDst;
    o.rw   = bus.RegWrite;
    o.sa   = bus.ALUSrcA;
    o.sb   = bus.ALUSrcB;
    o.aop  = bus.ALUOp;
    return o;
  endfunction

  // Control word for each named step of the instruction flow.
  function automatic outs_t ref_outs(int st, logic [5:0] op, logic zero);
    outs_t o;
    o = '0;
    case (st)
      0:  begin o.mr = 1; o.irw = 1; o.sb = 2'd1; o.pcw = 1; end
      1:  begin o.sb = 2'd3; end
      2:  begin o.sa = 1; o.sb = 2'd2; end
      3:  begin o.mr = 1; o.iord = 1; end
      4:  begin o.rw = 1; o.m2r = 1; end
      5:  begin o.mw = 1; o.iord = 1; end
      6:  begin o.sa = 1; o.aop = 2'd2; end
      7:  begin o.rw = 1; o.rd = 1; end
      8:  begin
            o.sa = 1; o.aop = 2'd1; o.pcs = 2'd1;
            o.pcw = ((op == 6'h04) && zero) || ((op == 6'h05) && !zero);
          end
      9:  begin o.pcs = 2'd2; o.pcw = 1; end
      10: begin o.sa = 1; o.sb = 2'd2; end
      11: begin o.rw = 1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  // Steps an instruction walks through after FETCH.
  function automatic void plan_for(input logic [5:0] op, output int q[$]);
    q = {};
    case (op)
      6'h23:        q = {1, 2, 3, 4};
      6'h2B:        q = {1, 2, 5};
      6'h00:        q = {1, 6, 7};
      6'h08:        q = {1, 10, 11};
      6'h04, 6'h05: q = {1, 8};
      6'h02:        q = {1, 9};
      default:      q = {1};
    endcase
  endfunction

  task automatic add(input logic rst, input logic [5:0] op, input logic zero,
                     input int st, input logic pcw, input logic [1:0] pcs,
                     input logic rw, input logic mw, input logic mr,
                     input logic rd, input logic iord);
    vec_t v;
    v.rst = rst; v.op = op; v.zero = zero; v.st = st; v.pcw = pcw;
    v.pcs = pcs; v.rw = rw; v.mw = mw; v.mr = mr; v.rd = rd; v.iord = iord;
    vecs.push_back(v);
  endtask

  task automatic check_state(input string name, input int exp);
    checks++;
    if (int'(bus.State) != exp) begin
      errors++;
      $display("FAIL %s: State got %0d expected %0d", name, bus.State, exp);
    end
  endtask

  task automatic check_outs(input string name, input outs_t exp);
    outs_t got;
    got = dut_outs();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: outputs got %h expected %h (state %0d)",
               name, got, exp, bus.State);
    end
  endtask

  // Runs one instruction from FETCH and counts cycles until FETCH returns.
  task automatic run_instr(input logic [5:0] op, input int exp_cycles);
    int n;
    bus.Op = op;
    bus.Zero = 1'b0;
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (bus.State != 4'd0 && n < 20);
    checks++;
    if (n != exp_cycles) begin
      errors++;
      $display("FAIL cpi_op%02h: cycles got %0d expected %0d", op, n, exp_cycles);
    end
  endtask

  logic [5:0] legal_ops [7] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02};

  initial begin
    logic [7:0] got_k;
    logic [7:0] exp_k;
    int         m_state;
    int         plan[$];
    logic [5:0] op;
    logic       zero;
    logic       rst;

    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.Op = 6'h23;
    bus.Zero = 1'b0;
    @(posedge clock); #1;

    // Directed vectors: {rst, op, zero, state, pcw, pcs, rw, mw, mr, rd, iord}
    add(1, 6'h23, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    add(1, 6'h23, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 6'h23, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 6'h23, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 6'h23, 0, 2, 0, 0, 0, 0, 0, 0, 0);
    add(0, 6'h23, 0, 3, 0, 0, 0, 0, 1, 0, 1);
    add(0, 6'h23, 0, 4, 0, 0, 1, 0, 0, 0, 0);
    add(0, 6'h04, 1, 0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 6'h04, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 6'h04, 1, 8, 1, 1, 0, 0, 0, 0, 0);
    add(0, 6'h04, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 6'h04, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 6'h04, 0, 8, 0, 1, 0, 0, 0, 0, 0);
    add(0, 6'h05, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 6'h05, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 6'h05, 0, 8, 1, 1, 0, 0, 0, 0, 0);
    add(0, 6'h05, 1, 0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 6'h05, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 6'h05, 1, 8, 0, 1, 0, 0, 0, 0, 0);
    add(0, 6'h00, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 6'h00, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 6'h00, 0, 6, 0, 0, 0, 0, 0, 0, 0);
    add(0, 6'h00, 0, 7, 0, 0, 1, 0, 0, 1, 0);
    add(0, 6'h2B, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 6'h2B, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 6'h2B, 0, 2, 0, 0, 0, 0, 0, 0, 0);
    add(0, 6'h2B, 0, 5, 0, 0, 0, 1, 0, 0, 1);
    add(0, 6'h02, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 6'h02, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 6'h02, 0, 9, 1, 2, 0, 0, 0, 0, 0);
    add(0, 6'h08, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 6'h08, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 6'h08, 0, 10, 0, 0, 0, 0, 0, 0, 0);
    add(0, 6'h08, 0, 11, 0, 0, 1, 0, 0, 0, 0);
    add(0, 6'h3F, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 6'h3F, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 6'h23, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 6'h23, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 6'h23, 0, 2, 0, 0, 0, 0, 0, 0, 0);
    add(1, 6'h23, 0, 3, 0, 0, 0, 0, 1, 0, 1);
    add(0, 6'h23, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 6'h23, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 6'h23, 0, 2, 0, 0, 0, 0, 0, 0, 0);

    // Apply each vector, compare, then clock it in.
    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst;
      bus.Op = vecs[i].op;
      bus.Zero = vecs[i].zero;
      #1;
      check_state($sformatf("vec%0d_state", i), vecs[i].st);
      got_k = {bus.PCWrite, bus.PCSource, bus.RegWrite, bus.MemWrite,
               bus.MemRead, bus.RegDst, bus.IorD};
      exp_k = {vecs[i].pcw, vecs[i].pcs, vecs[i].rw, vecs[i].mw,
               vecs[i].mr, vecs[i].rd, vecs[i].iord};
      checks++;
      if (got_k !== exp_k) begin
        errors++;
        $display("FAIL vec%0d_outs: got %b expected %b", i, got_k, exp_k);
      end
      @(posedge clock); #1;
    end

    // Return to FETCH, then measure cycles per instruction back to back.
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    run_instr(6'h23, 5);
    run_instr(6'h2B, 4);
    run_instr(6'h00, 4);
    run_instr(6'h08, 4);
    run_instr(6'h04, 3);
    run_instr(6'h05, 3);
    run_instr(6'h02, 3);
    run_instr(6'h3F, 2);

    // Randomized run against the instruction-level model.
    reset = 1'b1;
    bus.Op = 6'h00;
    @(posedge clock); #1;
    m_state = 0;
    plan = {};
    op = 6'h00;
    for (int c = 0; c < 3000; c++) begin
      if (m_state == 0) begin
        if ($urandom_range(0, 7) == 0) op = 6'($urandom);
        else op = legal_ops[$urandom_range(0, 6)];
      end
      zero = 1'($urandom);
      rst = ($urandom_range(0, 39) == 0);
      reset = rst;
      bus.Op = op;
      bus.Zero = zero;
      #1;
      check_state("rand_state", m_state);
      check_outs("rand_outs", ref_outs(m_state, op, zero));
      checks++;
      if ((bus.MemRead && bus.MemWrite) || (bus.RegWrite && bus.PCWrite)) begin
        errors++;
        $display("FAIL rand_exclusive: MR=%b MW=%b RW=%b PCW=%b",
                 bus.MemRead, bus.MemWrite, bus.RegWrite, bus.PCWrite);
      end
      if (rst) begin
        plan = {};
        m_state = 0;
      end else if (m_state == 0) begin
        plan_for(op, plan);
        m_state = plan.pop_front();
      end else if (plan.size() > 0) begin
        m_state = plan.pop_front();
      end else begin
        m_state = 0;
      end
      @(posedge clock); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
